// File: rtl/cpa_pkg.sv
// cpa_pkg: shared state type, default sizing and carry-width helper for carry_propagate_serial
package cpa_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} cpa_state_t;
   localparam int CPA_NUM_COLS = 66;
   localparam int CPA_WORD_LEN = 16;
   localparam int CPA_IN_BIT_LEN = 28;
   localparam int CPA_COLS_PER_CYCLE = 2;
   localparam int CPA_NUM_SLICES = CPA_NUM_COLS / CPA_COLS_PER_CYCLE;
   function automatic int cpa_carry_len(input int in_bit_len, input int word_len);
      return in_bit_len - word_len + 2;
   endfunction
endpackage

// File: rtl/cpa_column_slice.sv
// cpa_column_slice: combinational ripple of COLS column adders, each emitting one radix word
module cpa_column_slice #(
   parameter int WORD_LEN = 16,
   parameter int IN_BIT_LEN = 28,
   parameter int COLS = 2,
   parameter int CARRY_LEN = 14
) (
   input  logic [CARRY_LEN-1:0]  cin,
   input  logic [IN_BIT_LEN-1:0] c [COLS],
   input  logic [IN_BIT_LEN-1:0] s [COLS],
   output logic [WORD_LEN-1:0]   w [COLS],
   output logic [CARRY_LEN-1:0]  cout
);
   logic [CARRY_LEN-1:0]  ch [COLS+1];
   logic [IN_BIT_LEN+1:0] t [COLS];
   assign ch[0] = cin;
   assign cout = ch[COLS];
   for (genvar g = 0; g < COLS; g++) begin : g_col
      assign t[g] = {2'b00, c[g]} + {2'b00, s[g]} + (IN_BIT_LEN+2)'(ch[g]);
      assign w[g] = t[g][WORD_LEN-1:0];
      assign ch[g+1] = CARRY_LEN'(t[g] >> WORD_LEN);
   end
endmodule

// File: rtl/carry_propagate_serial.sv
// carry_propagate_serial: serial column carry resolution into WORD_LEN-radix words plus carry-out
// CPA_OVERFLOW_FLAG_EN builds the registered overflow flag; otherwise overflow is tied low
module carry_propagate_serial
   import cpa_pkg::*;
#(
   parameter int NUM_COLS = CPA_NUM_COLS,
   parameter int WORD_LEN = CPA_WORD_LEN,
   parameter int IN_BIT_LEN = CPA_IN_BIT_LEN,
   parameter int COLS_PER_CYCLE = CPA_COLS_PER_CYCLE,
   parameter int CARRY_LEN = cpa_carry_len(IN_BIT_LEN, WORD_LEN)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_BIT_LEN-1:0] in_C [NUM_COLS],
   input  logic [IN_BIT_LEN-1:0] in_S [NUM_COLS],
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORD_LEN-1:0]   P [NUM_COLS],
   output logic [CARRY_LEN-1:0]  carry_out,
   output logic                  overflow
);
   localparam int NUM_SLICES = NUM_COLS / COLS_PER_CYCLE;
   localparam int IW = NUM_SLICES > 1 ? $clog2(NUM_SLICES) : 1;
   localparam int CW = NUM_COLS > 1 ? $clog2(NUM_COLS) : 1;
   cpa_state_t state, state_nx;
   logic [IW-1:0] idx;
   logic [CW-1:0] base;
   logic [CARRY_LEN-1:0] carry, slice_cout;
   logic [IN_BIT_LEN-1:0] c_buf [NUM_COLS];
   logic [IN_BIT_LEN-1:0] s_buf [NUM_COLS];
   logic [IN_BIT_LEN-1:0] c_sl [COLS_PER_CYCLE];
   logic [IN_BIT_LEN-1:0] s_sl [COLS_PER_CYCLE];
   logic [WORD_LEN-1:0] w_sl [COLS_PER_CYCLE];
   logic take, last;
   always_comb begin
      in_ready = state == IDLE || (state == DONE && out_ready);
      out_valid = state == DONE;
      take = in_valid && in_ready;
      last = idx == IW'(NUM_SLICES - 1);
      base = CW'(int'(idx) * COLS_PER_CYCLE);
      state_nx = take ? RUN :
                 (state == RUN && last) ? DONE :
                 (state == DONE && out_ready) ? IDLE : state;
   end
   for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_mux
      assign c_sl[j] = c_buf[base + CW'(j)];
      assign s_sl[j] = s_buf[base + CW'(j)];
   end
   cpa_column_slice #(
      .WORD_LEN(WORD_LEN), .IN_BIT_LEN(IN_BIT_LEN), .COLS(COLS_PER_CYCLE), .CARRY_LEN(CARRY_LEN)
   ) u_slice (.cin(carry), .c(c_sl), .s(s_sl), .w(w_sl), .cout(slice_cout));
   // operand buffer needs no reset: it is only read in RUN, which always follows a capture
   always_ff @(posedge clk) begin
      if (take) begin
         c_buf <= in_C;
         s_buf <= in_S;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         idx <= '0;
         carry <= '0;
         carry_out <= '0;
         P <= '{default: '0};
      end else begin
         state <= state_nx;
         if (take) begin
            idx <= '0;
            carry <= '0;
         end else if (state == RUN) begin
            idx <= idx + IW'(1);
            carry <= slice_cout;
            for (int k = 0; k < COLS_PER_CYCLE; k++) P[base + CW'(k)] <= w_sl[k];
            if (last) carry_out <= slice_cout;
         end
      end
   end
`ifdef CPA_OVERFLOW_FLAG_EN
   always_ff @(posedge clk) begin
      if (!rst_n) overflow <= 1'b0;
      else if (state == RUN && last) overflow <= |slice_cout;
   end
`else
   assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_carry_propagate_serial.sv
// tb_carry_propagate_serial: directed and modelled checks of carry_propagate_serial at default sizing
module tb_carry_propagate_serial;
   localparam int N = 66;
   localparam int LAT = 34;
   typedef logic [27:0] col_t [N];
   typedef logic [15:0] wrd_t [N];
   logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
   logic in_ready, out_valid, overflow;
   logic [27:0] in_C [N];
   logic [27:0] in_S [N];
   logic [15:0] P [N];
   logic [13:0] carry_out;
   int total = 0, bad = 0;
   col_t ca, sa, cb, sb;
   wrd_t ep, ep2;
   logic [13:0] eco, eco2;
   always #5 clk = ~clk;
   carry_propagate_serial dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_C(in_C), .in_S(in_S), .out_valid(out_valid), .out_ready(out_ready),
      .P(P), .carry_out(carry_out), .overflow(overflow)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic model(input col_t c, input col_t s, output wrd_t p, output logic [13:0] co);
      logic [1087:0] tot;
      tot = '0;
      for (int k = 0; k < N; k++) tot = tot + ((1088'(c[k]) + 1088'(s[k])) << (16 * k));
      for (int k = 0; k < N; k++) p[k] = tot[16*k +: 16];
      co = 14'(tot >> 1056);
   endtask
   task automatic scramble();
      for (int k = 0; k < N; k++) begin
         in_C[k] = 28'($urandom);
         in_S[k] = 28'($urandom);
      end
   endtask
   task automatic start(input col_t c, input col_t s);
      int n = 0;
      in_C = c;
      in_S = s;
      in_valid = 1;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("cap_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 0;
      scramble();
   endtask
   task automatic wait_result(input wrd_t p, input logic [13:0] co);
      int n = 0;
      logic eo;
      while (!out_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n + 1, LAT);
      chk("done_ready", in_ready, out_ready);
      for (int k = 0; k < N; k++) chk($sformatf("P[%0d]", k), P[k], p[k]);
      chk("carry_out", carry_out, co);
      eo = 0;
`ifdef CPA_OVERFLOW_FLAG_EN
      eo = |co;
`endif
      chk("overflow", overflow, eo);
   endtask
   task automatic accept();
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk("valid_drop", out_valid, 0);
      chk("idle_ready", in_ready, 1);
   endtask
   initial begin
      scramble();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", in_ready, 1);
      chk("rst_valid", out_valid, 0);
      chk("rst_co", carry_out, 0);
      chk("rst_ov", overflow, 0);
      chk("rst_p0", P[0], 0);
      rst_n = 1;
      // S[k] = k, C = 0: P[k] = k, no carry anywhere
      for (int k = 0; k < N; k++) begin
         ca[k] = 0;
         sa[k] = 28'(k);
         ep[k] = 16'(k);
      end
      start(ca, sa);
      wait_result(ep, 14'd0);
      accept();
      // 0x1FFFF + 1 = 0x20000: P[0] = 0, carry 2 lands in P[1]
      for (int k = 0; k < N; k++) begin
         ca[k] = 0;
         sa[k] = 0;
         ep[k] = 0;
      end
      sa[0] = 28'h1FFFF;
      ca[0] = 28'd1;
      ep[1] = 16'h0002;
      start(ca, sa);
      wait_result(ep, 14'd0);
      accept();
      for (int k = 0; k < N; k++) begin
         ca[k] = 28'hFFFFFFF;
         sa[k] = 28'hFFFFFFF;
      end
      model(ca, sa, ep, eco);
      chk("allones_co_nz", (eco != 0), 1);
      start(ca, sa);
      wait_result(ep, eco);
      accept();
      // abort mid-RUN: every output must be back at reset values one edge later
      start(ca, sa);
      repeat (5) begin
         @(posedge clk); #1;
      end
      rst_n = 0;
      @(posedge clk); #1;
      chk("abort_valid", out_valid, 0);
      chk("abort_ready", in_ready, 1);
      chk("abort_co", carry_out, 0);
      chk("abort_p0", P[0], 0);
      rst_n = 1;
      for (int k = 0; k < N; k++) begin
         ca[k] = 28'($urandom);
         sa[k] = 28'($urandom);
         cb[k] = 28'($urandom);
         sb[k] = 28'($urandom);
      end
      model(ca, sa, ep, eco);
      model(cb, sb, ep2, eco2);
      start(ca, sa);
      wait_result(ep, eco);
      repeat (10) begin
         @(posedge clk); #1;
         chk("hold_valid", out_valid, 1);
         chk("hold_ready", in_ready, 0);
         chk("hold_p7", P[7], ep[7]);
         chk("hold_co", carry_out, eco);
      end
      // consume and capture in the same edge
      in_C = cb;
      in_S = sb;
      in_valid = 1;
      out_ready = 1;
      @(posedge clk); #1;
      in_valid = 0;
      out_ready = 0;
      scramble();
      chk("b2b_valid", out_valid, 0);
      wait_result(ep2, eco2);
      accept();
      for (int r = 0; r < 20; r++) begin
         for (int k = 0; k < N; k++) begin
            ca[k] = 28'($urandom);
            sa[k] = 28'($urandom);
         end
         model(ca, sa, ep, eco);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         start(ca, sa);
         wait_result(ep, eco);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         accept();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
